// File: rtl/mem_banked_pkg.sv
// Shared constants, clear-sequencer state type and a constant log2 helper
// for the banked register-file memory.
package mem_banked_pkg;

  localparam int RF_ROWS  = 32;
  localparam int RF_WIDTH = 32;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_banked_clr.sv
// Clear sequencer: sweeps a 5-bit row counter once through all 32 rows,
// zeroing that row in every bank in parallel.
module mem_banked_clr
  import mem_banked_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr_req,
  output logic       o_busy,
  output logic       o_clr_we,
  output logic [4:0] o_clr_row
);

  clr_state_e r_state;
  clr_state_e w_state_nxt;
  logic [4:0] r_row;
  logic [4:0] w_row_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= CLR_CLEAR;
      r_row   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    o_clr_we    = 1'b0;
    case (r_state)
      CLR_IDLE: begin
        if (i_clr_req) begin
          w_state_nxt = CLR_CLEAR;
          w_row_nxt   = '0;
        end
      end
      CLR_CLEAR: begin
        o_clr_we  = ~i_rst;
        w_row_nxt = r_row + 5'd1;
        if (r_row == 5'd31) w_state_nxt = CLR_IDLE;
      end
      default: w_state_nxt = CLR_IDLE;
    endcase
  end

  assign o_busy    = (r_state == CLR_CLEAR);
  assign o_clr_row = r_row;

endmodule

// File: rtl/rf_top.sv
// 32x32 register file: one synchronous write port, two registered read ports.
module rf_top
  import mem_banked_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_we,
  input  logic [4:0]          i_waddr,
  input  logic [RF_WIDTH-1:0] i_wdata,
  input  logic [4:0]          i_ra_addr,
  input  logic [4:0]          i_rb_addr,
  output logic [RF_WIDTH-1:0] o_ra_data,
  output logic [RF_WIDTH-1:0] o_rb_data
);

  logic [RF_WIDTH-1:0] r_mem [RF_ROWS];
  logic [RF_WIDTH-1:0] r_ra_data_p0;
  logic [RF_WIDTH-1:0] r_rb_data_p0;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_ra_data_p0 <= r_mem[i_ra_addr];
    r_rb_data_p0 <= r_mem[i_rb_addr];
  end

  assign o_ra_data = r_ra_data_p0;
  assign o_rb_data = r_rb_data_p0;

endmodule

// File: rtl/mem_banked.sv
// Banked memory of NUM_BANKS x 32 rows, one write and two read ports, with a
// full-memory clear. Define MEM_BANKED_FWD_EN to forward same-edge write data.
module mem_banked
  import mem_banked_pkg::*;
#(
  parameter int NUM_BANKS  = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr_req,
  output logic                          busy,
  input  logic                          w_ena,
  input  logic [5+clog2(NUM_BANKS)-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0]         w_data,
  input  logic [5+clog2(NUM_BANKS)-1:0] ra_addr,
  output logic [DATA_WIDTH-1:0]         ra_data,
  input  logic [5+clog2(NUM_BANKS)-1:0] rb_addr,
  output logic [DATA_WIDTH-1:0]         rb_data
);

  localparam int BANK_BITS = clog2(NUM_BANKS);
  localparam int AW        = 5 + BANK_BITS;
  localparam int DEPTH     = RF_ROWS * NUM_BANKS;
  localparam int COLS      = DATA_WIDTH / RF_WIDTH;
  localparam int SW        = (BANK_BITS > 0) ? BANK_BITS : 1;

  logic                  w_busy;
  logic                  w_clr_we;
  logic [4:0]            w_clr_row;
  logic                  w_wr_ok;
  logic [SW-1:0]         w_wbank;
  logic [SW-1:0]         w_abank;
  logic [SW-1:0]         w_bbank;
  logic [NUM_BANKS-1:0]  w_bank_we;
  logic [4:0]            w_rf_waddr;
  logic [DATA_WIDTH-1:0] w_rf_wdata;
  logic [DATA_WIDTH-1:0] w_a_bank [NUM_BANKS];
  logic [DATA_WIDTH-1:0] w_b_bank [NUM_BANKS];
  logic [SW-1:0]         r_abank_p0;
  logic [SW-1:0]         r_bbank_p0;
  logic                  r_zero_p0;

  mem_banked_clr u_clr (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_clr_req (clr_req),
    .o_busy    (w_busy),
    .o_clr_we  (w_clr_we),
    .o_clr_row (w_clr_row)
  );

  assign busy    = w_busy;
  assign w_wr_ok = w_ena & ~w_busy & ~rst;

  if (DEPTH > RF_ROWS) begin : g_bank_sel
    assign w_wbank = w_addr[AW-1:5];
    assign w_abank = ra_addr[AW-1:5];
    assign w_bbank = rb_addr[AW-1:5];
  end else begin : g_single_bank
    assign w_wbank = '0;
    assign w_abank = '0;
    assign w_bbank = '0;
  end

  // A clear owns the write port of every bank and column at once.
  assign w_rf_waddr = w_clr_we ? w_clr_row : w_addr[4:0];
  assign w_rf_wdata = w_clr_we ? '0 : w_data;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign w_bank_we[b] = w_clr_we | (w_wr_ok & (w_wbank == SW'(b)));
    for (genvar c = 0; c < COLS; c++) begin : g_col
      rf_top u_rf (
        .i_clk     (clk),
        .i_we      (w_bank_we[b]),
        .i_waddr   (w_rf_waddr),
        .i_wdata   (w_rf_wdata[c*RF_WIDTH +: RF_WIDTH]),
        .i_ra_addr (ra_addr[4:0]),
        .i_rb_addr (rb_addr[4:0]),
        .o_ra_data (w_a_bank[b][c*RF_WIDTH +: RF_WIDTH]),
        .o_rb_data (w_b_bank[b][c*RF_WIDTH +: RF_WIDTH])
      );
    end
  end

  // p0: bank selects and read-zero flag, aligned with the registered rf reads
  always_ff @(posedge clk) begin
    if (rst) begin
      r_abank_p0 <= '0;
      r_bbank_p0 <= '0;
      r_zero_p0  <= 1'b1;
    end else begin
      r_abank_p0 <= w_abank;
      r_bbank_p0 <= w_bbank;
      r_zero_p0  <= w_busy;
    end
  end

`ifdef MEM_BANKED_FWD_EN
  logic                  r_fwd_a_p0;
  logic                  r_fwd_b_p0;
  logic [DATA_WIDTH-1:0] r_fwd_data_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwd_a_p0 <= 1'b0;
      r_fwd_b_p0 <= 1'b0;
    end else begin
      r_fwd_a_p0 <= w_wr_ok & (ra_addr == w_addr);
      r_fwd_b_p0 <= w_wr_ok & (rb_addr == w_addr);
    end
  end

  always_ff @(posedge clk) begin
    r_fwd_data_p0 <= w_data;
  end

  assign ra_data = r_zero_p0  ? '0 :
                   r_fwd_a_p0 ? r_fwd_data_p0 : w_a_bank[r_abank_p0];
  assign rb_data = r_zero_p0  ? '0 :
                   r_fwd_b_p0 ? r_fwd_data_p0 : w_b_bank[r_bbank_p0];
`else
  assign ra_data = r_zero_p0 ? '0 : w_a_bank[r_abank_p0];
  assign rb_data = r_zero_p0 ? '0 : w_b_bank[r_bbank_p0];
`endif

endmodule

// File: tb/tb_mem_banked.sv
// Randomized and directed bench for mem_banked (NUM_BANKS=4, DATA_WIDTH=64)
// against a word-array reference model.
module tb_mem_banked;

  localparam int NB    = 4;
  localparam int DW    = 64;
  localparam int AW    = 7;
  localparam int DEPTH = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr_req;
  logic          busy;
  logic          w_ena;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic [AW-1:0] ra_addr;
  logic [DW-1:0] ra_data;
  logic [AW-1:0] rb_addr;
  logic [DW-1:0] rb_data;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem_m [DEPTH];
  int            busy_left;

  mem_banked #(.NUM_BANKS(NB), .DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .clr_req (clr_req),
    .busy    (busy),
    .w_ena   (w_ena),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .ra_addr (ra_addr),
    .ra_data (ra_data),
    .rb_addr (rb_addr),
    .rb_data (rb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void predict(input logic [AW-1:0] addr, input bit wr_ok,
                                  output bit do_chk, output logic [DW-1:0] exp);
    do_chk = 1'b1;
    if (rst || busy_left > 0) exp = '0;
    else if (wr_ok && addr == w_addr) begin
`ifdef MEM_BANKED_FWD_EN
      exp = w_data;
`else
      exp = '0;
      do_chk = 1'b0;
`endif
    end else exp = mem_m[addr];
  endfunction

  // One clock: predict outputs from pre-edge state, advance model, check.
  task automatic tick();
    bit            wr_ok, ca, cb;
    logic [DW-1:0] ea, eb;
    wr_ok = w_ena && (busy_left == 0) && !rst;
    predict(ra_addr, wr_ok, ca, ea);
    predict(rb_addr, wr_ok, cb, eb);
    @(posedge clk);
    if (rst) begin
      busy_left = 32;
      foreach (mem_m[i]) mem_m[i] = '0;
    end else if (busy_left > 0) begin
      busy_left--;
    end else begin
      if (wr_ok) mem_m[w_addr] = w_data;
      if (clr_req) begin
        busy_left = 32;
        foreach (mem_m[i]) mem_m[i] = '0;
      end
    end
    #1;
    chk("busy", {63'd0, busy}, {63'd0, busy_left > 0});
    if (ca) chk("ra_data", ra_data, ea);
    if (cb) chk("rb_data", rb_data, eb);
  endtask

  task automatic busy_len(input string tag);
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk(tag, DW'(n), DW'(32));
  endtask

  task automatic idle_inputs();
    rst = 1'b0; clr_req = 1'b0; w_ena = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr_req = 1'b0; w_ena = 1'b0;
    w_addr = '0; w_data = '0; ra_addr = '0; rb_addr = '0;
    busy_left = 32;
    foreach (mem_m[i]) mem_m[i] = '0;

    // reset for three cycles, then a full clear
    repeat (3) tick();
    rst = 1'b0;
    busy_len("rst_busy_len");
    for (int i = 0; i < 4; i++) begin
      ra_addr = AW'($urandom_range(0, DEPTH-1));
      rb_addr = AW'($urandom_range(0, DEPTH-1));
      tick();
    end

    // two wide words in different banks, read back on both ports
    w_ena = 1'b1; w_addr = 7'h45; w_data = 64'hDEADBEEF_01234567; tick();
    w_addr = 7'h05; w_data = 64'h12345678_9ABCDEF0; tick();
    w_ena = 1'b0; ra_addr = 7'h45; rb_addr = 7'h05; tick();
    chk("rd_a_45", ra_data, 64'hDEADBEEF_01234567);
    chk("rd_b_05", rb_data, 64'h12345678_9ABCDEF0);
    ra_addr = 7'h05; rb_addr = 7'h05; tick();
    chk("same_word_a", ra_data, 64'h12345678_9ABCDEF0);
    chk("same_word_b", rb_data, 64'h12345678_9ABCDEF0);

    // clear with a dropped write and an ignored second request
    w_ena = 1'b1; w_addr = 7'd7; w_data = 64'hA5A5A5A5; tick();
    w_ena = 1'b0; clr_req = 1'b1; tick();
    clr_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w_ena = (i == 2); w_addr = 7'd3; w_data = 64'hFFFF_0000_FFFF_0000;
      clr_req = (i == 4);
      tick();
    end
    idle_inputs();
    begin
      int n;
      n = 5;
      while (busy && n < 100) begin tick(); n++; end
      chk("clr_busy_len", DW'(n), DW'(32));
    end
    ra_addr = 7'd7; rb_addr = 7'd3; tick();
    chk("clr_addr7", ra_data, '0);
    chk("clr_addr3", rb_data, '0);

    // write and clear request at the same idle edge
    w_ena = 1'b1; w_addr = 7'd20; w_data = 64'h55; clr_req = 1'b1; tick();
    idle_inputs();
    busy_len("wr_clr_busy_len");
    ra_addr = 7'd20; tick();
    chk("wr_then_clr", ra_data, '0);

    // reset in the middle of a clear restarts it
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    repeat (10) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    busy_len("midclr_rst_len");

`ifdef MEM_BANKED_FWD_EN
    w_ena = 1'b1; w_addr = 7'd9; w_data = 64'h11; ra_addr = 7'd9; rb_addr = 7'd10; tick();
    w_ena = 1'b0;
    chk("fwd_a", ra_data, 64'h11);
`endif

    // randomized traffic, addresses biased toward a few hot words
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 599) == 0);
      clr_req = ($urandom_range(0, 249) == 0);
      w_ena   = ($urandom_range(0, 1) == 1);
      w_addr  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      w_data  = {$urandom, $urandom};
      ra_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      rb_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
